// File: rtl/imm_pkg.sv
// Shared constants for the immediate-extension path: mode encodings, field
// widths and the skid-stage state encoding.
package imm_pkg;

   localparam logic [2:0] IMM5_ZE      = 3'b000;
   localparam logic [2:0] IMM15_SE     = 3'b001;
   localparam logic [2:0] IMM15_ZE     = 3'b010;
   localparam logic [2:0] IMM20_SE     = 3'b011;
   localparam logic [2:0] IMM14_SE     = 3'b100;
   localparam logic [2:0] IMM24_SE     = 3'b101;
   localparam logic [2:0] IMM24_SE_SH1 = 3'b110;
   localparam logic [2:0] IMM_ILLEGAL  = 3'b111;

   localparam int W_IMM5  = 5;
   localparam int W_IMM14 = 14;
   localparam int W_IMM15 = 15;
   localparam int W_IMM20 = 20;
   localparam int W_IMM24 = 24;

   // Bit 0 is the output-register valid, bit 1 the skid valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } skid_state_e;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Valid/ready bus around the immediate-extension stage: decode-side input
// stream and execute-side output stream.
interface imm_extend_stage_if #(
   parameter int DataSize = 32,
   parameter int RawWidth = 24,
   parameter int TagWidth = 5
);
   logic                in_valid;
   logic                in_ready;
   logic [RawWidth-1:0] in_imm_raw;
   logic [2:0]          in_imm_select;
   logic [TagWidth-1:0] in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [DataSize-1:0] out_imm;
   logic [TagWidth-1:0] out_tag;
   logic                out_illegal;

   modport master (
      output in_valid, in_imm_raw, in_imm_select, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_imm_raw, in_imm_select, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_extend_comb.sv
// Purely combinational immediate extender: right-aligned raw field plus mode
// select to a DataSize-bit zero/sign-extended immediate and illegal flag.
module imm_extend_comb
   import imm_pkg::*;
#(
   parameter int DataSize = 32,
   parameter int RawWidth = 24
) (
   input  logic [RawWidth-1:0] raw,
   input  logic [2:0]          sel,
   output logic [DataSize-1:0] imm,
   output logic                illegal
);

   function automatic logic [DataSize-1:0] low_mask(input int n);
      logic [DataSize-1:0] m;
      m = '0;
      for (int i = 0; i < DataSize; i++) m[i] = (i < n);
      return m;
   endfunction

   function automatic logic [DataSize-1:0] extend(
      input logic [DataSize-1:0] r,
      input int                  n,
      input logic                fill
   );
      logic [DataSize-1:0] m;
      m = low_mask(n);
      return (r & m) | (~m & {DataSize{fill}});
   endfunction

   logic [DataSize-1:0] raw_wide;
   logic [DataSize-1:0] ext24;

   assign raw_wide = DataSize'(raw);
   assign ext24    = extend(raw_wide, W_IMM24, raw[W_IMM24-1]);

   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (sel)
         IMM5_ZE:      imm = extend(raw_wide, W_IMM5,  1'b0);
         IMM15_SE:     imm = extend(raw_wide, W_IMM15, raw[W_IMM15-1]);
         IMM15_ZE:     imm = extend(raw_wide, W_IMM15, 1'b0);
         IMM20_SE:     imm = extend(raw_wide, W_IMM20, raw[W_IMM20-1]);
         IMM14_SE:     imm = extend(raw_wide, W_IMM14, raw[W_IMM14-1]);
         IMM24_SE:     imm = ext24;
         // Halfword branch offset: the top sign copy falls off the shift.
         IMM24_SE_SH1: imm = ext24 << 1;
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer so that
// in_ready comes straight from a flop.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | nothing held; in_ready=1, out_valid=0
// ST_ONE   | output register holds an entry; skid empty
// ST_FULL  | output and skid both hold entries; in_ready=0
module imm_extend_stage
   import imm_pkg::*;
#(
   parameter int DataSize = 32,
   parameter int RawWidth = 24,
   parameter int TagWidth = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   imm_extend_stage_if.slave  bus
);

   skid_state_e state_q, state_d;

   logic                in_xfer;
   logic                out_xfer;
   logic                load_out_new;
   logic                load_out_skid;
   logic                load_skid;

   logic [DataSize-1:0] new_imm;
   logic                new_illegal;

   logic [DataSize-1:0] out_imm_q;
   logic [TagWidth-1:0] out_tag_q;
   logic                out_illegal_q;
   logic [DataSize-1:0] skid_imm_q;
   logic [TagWidth-1:0] skid_tag_q;
   logic                skid_illegal_q;

   imm_extend_comb #(
      .DataSize (DataSize),
      .RawWidth (RawWidth)
   ) u_ext (
      .raw     (bus.in_imm_raw),
      .sel     (bus.in_imm_select),
      .imm     (new_imm),
      .illegal (new_illegal)
   );

   assign bus.out_valid   = state_q[0];
   assign bus.in_ready    = ~state_q[1];
   assign bus.out_imm     = out_imm_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.out_illegal = out_illegal_q;

   assign in_xfer  = bus.in_valid  & bus.in_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d      = ST_ONE;
               load_out_new = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_out_new = 1'b1;
            end else if (in_xfer) begin
               state_d   = ST_FULL;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               state_d       = ST_ONE;
               load_out_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins over any handshake; a same-cycle input is dropped.
      if (flush) begin
         state_d       = ST_EMPTY;
         load_out_new  = 1'b0;
         load_out_skid = 1'b0;
         load_skid     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_imm_q      <= '0;
         out_tag_q      <= '0;
         out_illegal_q  <= 1'b0;
         skid_imm_q     <= '0;
         skid_tag_q     <= '0;
         skid_illegal_q <= 1'b0;
      end else begin
         if (load_skid) begin
            skid_imm_q     <= new_imm;
            skid_tag_q     <= bus.in_tag;
            skid_illegal_q <= new_illegal;
         end
         if (load_out_new) begin
            out_imm_q     <= new_imm;
            out_tag_q     <= bus.in_tag;
            out_illegal_q <= new_illegal;
         end else if (load_out_skid) begin
            out_imm_q     <= skid_imm_q;
            out_tag_q     <= skid_tag_q;
            out_illegal_q <= skid_illegal_q;
         end
      end
   end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: a 32-bit instance for the handshake and
// mode table, plus a 64-bit instance for wide-extension vectors.
module tb_imm_extend_stage;

   logic clk;
   logic rst;
   logic flush;
   int   total;
   int   bad;

   logic [31:0] exp_imm [8];

   imm_extend_stage_if #(.DataSize(32), .RawWidth(24), .TagWidth(5)) if32 ();
   imm_extend_stage_if #(.DataSize(64), .RawWidth(24), .TagWidth(5)) if64 ();

   imm_extend_stage #(.DataSize(32), .RawWidth(24), .TagWidth(5)) dut32 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (if32)
   );

   imm_extend_stage #(.DataSize(64), .RawWidth(24), .TagWidth(5)) dut64 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (if64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive32(input logic v, input logic [2:0] sel, input logic [23:0] raw,
                          input logic [4:0] tag);
      if32.in_valid      = v;
      if32.in_imm_select = sel;
      if32.in_imm_raw    = raw;
      if32.in_tag        = tag;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_imm = '{32'h0000_0001, 32'hFFFF_C321, 32'h0000_4321, 32'hFFFA_4321,
                  32'h0000_0321, 32'hFF8A_4321, 32'hFF14_8642, 32'h0000_0000};
      rst   = 1'b0;
      flush = 1'b0;
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      if32.out_ready     = 1'b0;
      if64.in_valid      = 1'b0;
      if64.in_imm_select = 3'b000;
      if64.in_imm_raw    = 24'h0;
      if64.in_tag        = 5'd0;
      if64.out_ready     = 1'b1;

      #3;
      chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
      chk("rst_in_ready",  64'(if32.in_ready),  64'd1);
      chk("rst_out_imm",   64'(if32.out_imm),   64'd0);
      chk("rst_illegal",   64'(if32.out_illegal), 64'd0);
      #9 rst = 1'b1;

      // Every mode back to back, one cycle after acceptance.
      if32.out_ready = 1'b1;
      for (int m = 0; m < 8; m++) begin
         drive32(1'b1, 3'(m), 24'h8A_4321, 5'(m));
         tick();
         chk($sformatf("mode%0d_valid", m), 64'(if32.out_valid), 64'd1);
         chk($sformatf("mode%0d_imm", m),   64'(if32.out_imm),   64'(exp_imm[m]));
         chk($sformatf("mode%0d_ill", m),   64'(if32.out_illegal), (m == 7) ? 64'd1 : 64'd0);
         chk($sformatf("mode%0d_tag", m),   64'(if32.out_tag),   64'(m));
      end
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      tick();
      chk("modes_drain", 64'(if32.out_valid), 64'd0);

      // Backpressure: fill to FULL, hold tag 3 upstream, then drain in order.
      if32.out_ready = 1'b0;
      drive32(1'b1, 3'b010, 24'h000011, 5'd1);
      tick();
      chk("bp_one_ready", 64'(if32.in_ready), 64'd1);
      chk("bp_one_tag",   64'(if32.out_tag),  64'd1);
      drive32(1'b1, 3'b010, 24'h000022, 5'd2);
      tick();
      chk("bp_full_ready", 64'(if32.in_ready), 64'd0);
      drive32(1'b1, 3'b010, 24'h000033, 5'd3);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_stall_ready", 64'(if32.in_ready), 64'd0);
         chk("bp_stall_imm",   64'(if32.out_imm),  64'h11);
         chk("bp_stall_tag",   64'(if32.out_tag),  64'd1);
      end
      if32.out_ready = 1'b1;
      tick();
      chk("bp_out2_tag",   64'(if32.out_tag),  64'd2);
      chk("bp_out2_imm",   64'(if32.out_imm),  64'h22);
      chk("bp_out2_ready", 64'(if32.in_ready), 64'd1);
      tick();
      chk("bp_out3_tag",   64'(if32.out_tag),   64'd3);
      chk("bp_out3_imm",   64'(if32.out_imm),   64'h33);
      chk("bp_out3_valid", 64'(if32.out_valid), 64'd1);
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      tick();
      chk("bp_drain", 64'(if32.out_valid), 64'd0);

      // Streaming: 100 entries at one per cycle.
      for (int i = 0; i < 100; i++) begin
         drive32(1'b1, 3'b010, 24'(i), 5'(i));
         tick();
         chk("stream_ready", 64'(if32.in_ready), 64'd1);
         chk("stream_imm",   64'(if32.out_imm),  64'(i));
         chk("stream_tag",   64'(if32.out_tag),  64'(i % 32));
      end
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      tick();
      chk("stream_drain", 64'(if32.out_valid), 64'd0);

      // Flush while FULL with a same-cycle input offered.
      if32.out_ready = 1'b0;
      drive32(1'b1, 3'b010, 24'h000055, 5'd5);
      tick();
      drive32(1'b1, 3'b010, 24'h000066, 5'd6);
      tick();
      chk("fl_full_ready", 64'(if32.in_ready), 64'd0);
      flush = 1'b1;
      drive32(1'b1, 3'b010, 24'h000077, 5'd7);
      tick();
      chk("fl_out_valid", 64'(if32.out_valid), 64'd0);
      chk("fl_in_ready",  64'(if32.in_ready),  64'd1);
      flush = 1'b0;
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      if32.out_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("fl_stays_empty", 64'(if32.out_valid), 64'd0);
      drive32(1'b1, 3'b010, 24'h000088, 5'd8);
      tick();
      chk("fl_after_tag", 64'(if32.out_tag), 64'd8);
      chk("fl_after_imm", 64'(if32.out_imm), 64'h88);
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      tick();
      chk("fl_after_drain", 64'(if32.out_valid), 64'd0);

      // 64-bit instance.
      if64.in_valid      = 1'b1;
      if64.in_imm_select = 3'b101;
      if64.in_imm_raw    = 24'h800000;
      tick();
      chk("w64_se24",   if64.out_imm, 64'hFFFF_FFFF_FF80_0000);
      chk("w64_valid",  64'(if64.out_valid), 64'd1);
      if64.in_imm_select = 3'b010;
      if64.in_imm_raw    = 24'hFFFFFF;
      tick();
      chk("w64_ze15",   if64.out_imm, 64'h0000_0000_0000_7FFF);
      if64.in_imm_select = 3'b110;
      if64.in_imm_raw    = 24'h800001;
      tick();
      chk("w64_sh1",    if64.out_imm, 64'hFFFF_FFFF_FF00_0002);
      if64.in_valid = 1'b0;
      tick();

      // Asynchronous reset while FULL.
      if32.out_ready = 1'b0;
      drive32(1'b1, 3'b000, 24'h00001F, 5'd9);
      tick();
      drive32(1'b1, 3'b000, 24'h00000E, 5'd10);
      tick();
      chk("ar_full_ready", 64'(if32.in_ready), 64'd0);
      chk("ar_full_imm",   64'(if32.out_imm),  64'h1F);
      drive32(1'b0, 3'b000, 24'h0, 5'd0);
      #2 rst = 1'b0;
      #1;
      chk("ar_out_valid", 64'(if32.out_valid), 64'd0);
      chk("ar_in_ready",  64'(if32.in_ready),  64'd1);
      chk("ar_out_imm",   64'(if32.out_imm),   64'd0);
      chk("ar_out_tag",   64'(if32.out_tag),   64'd0);
      #3 rst = 1'b1;
      if32.out_ready = 1'b1;
      tick();
      chk("ar_after_valid", 64'(if32.out_valid), 64'd0);
      chk("ar_after_ready", 64'(if32.in_ready),  64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
